// File: rtl/seg_scan_if.sv
`default_nettype none
// ============================================================================
//  Module   : seg_scan_if
//  Purpose  : Bundle of signals between the display decoder / board pins and
//             seg_scan_driver.
//  Signals  : en          - 1 = scan, 0 = all digits off, scanner parked
//             display0..5 - per-digit patterns, active-low segs, [7] = DP
//             seg         - shared segment bus, active-low (8'hFF = all off)
//             an          - digit enables, active-low, one-hot-low when lit
//             frame_done  - one-cycle pulse after digit 5 dwell completes
//  Modports : master - drives en/display*, observes seg/an/frame_done
//             slave  - the scan driver itself
//  Revision : 1.0  initial release
// ============================================================================
interface seg_scan_if;
    logic       en;
    logic [7:0] display0;
    logic [7:0] display1;
    logic [7:0] display2;
    logic [7:0] display3;
    logic [7:0] display4;
    logic [7:0] display5;
    logic [7:0] seg;
    logic [5:0] an;
    logic       frame_done;

    modport master (
        output en, display0, display1, display2, display3, display4, display5,
        input  seg, an, frame_done
    );

    modport slave (
        input  en, display0, display1, display2, display3, display4, display5,
        output seg, an, frame_done
    );
endinterface
`default_nettype wire

// File: rtl/seg_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module   : seg_scan_driver
//  Purpose  : Time-multiplexes six 7-segment digit patterns onto one shared
//             8-bit segment bus plus six active-low digit enables. All six
//             patterns are snapshotted once per frame (no tearing) and an
//             all-off blanking gap precedes every digit (no ghosting).
//  Params   : DWELL_CYCLES - clocks each digit is lit (>= 1)
//             BLANK_CYCLES - clocks all digits are off before each digit
//                            (0 = no gap)
//  Ports    : clk   - system clock
//             rst_n - asynchronous active-low reset
//             bus   - seg_scan_if.slave (en, display0..5 in;
//                     seg, an, frame_done out)
//  Options  : LEADING_ZERO_BLANK_EN - when defined, leading "0" digits
//             (pattern 8'hC0, scanning from digit 5 down, digit 0 exempt)
//             are blanked at snapshot time; they keep their time slot.
//  Revision : 1.0  initial release
// ============================================================================
module seg_scan_driver #(
    parameter int DWELL_CYCLES = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  wire logic  clk,
    input  wire logic  rst_n,
    seg_scan_if.slave  bus
);

    // Counter wide enough for the longer of the two phases.
    localparam int c_max_phase = (DWELL_CYCLES > BLANK_CYCLES) ?
                                 ((DWELL_CYCLES > 2) ? DWELL_CYCLES : 2) :
                                 ((BLANK_CYCLES > 2) ? BLANK_CYCLES : 2);
    localparam int c_cw = $clog2(c_max_phase);

    typedef logic [c_cw-1:0] cnt_t;

    localparam cnt_t c_dwell_last = cnt_t'(DWELL_CYCLES - 1);
    localparam cnt_t c_blank_last = cnt_t'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic c_skip_blank = (BLANK_CYCLES == 0);
    localparam logic [2:0] c_last_idx = 3'd5;
    localparam logic [7:0] c_seg_off  = 8'hFF;
    localparam logic [5:0] c_an_off   = 6'b111111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BLANK = 2'd1,
        S_ON    = 2'd2
    } state_t;

    state_t           r_state;
    logic [2:0]       r_idx;
    cnt_t             r_cnt;
    logic             r_first;     // set by reset: first edge must snapshot
    logic [5:0][7:0]  r_snap;
    logic [7:0]       r_seg;
    logic [5:0]       r_an;
    logic             r_frame_done;

    state_t           w_state;
    logic [2:0]       w_idx;
    cnt_t             w_cnt;
    logic             w_load;
    logic             w_frame_done;
    logic [5:0][7:0]  w_capture;
    logic [5:0][7:0]  w_snap;
    logic [7:0]       w_seg;
    logic [5:0]       w_an;

    // ------------------------------------------------------------------
    // Patterns as they will be stored at a snapshot edge.
    // ------------------------------------------------------------------
`ifdef LEADING_ZERO_BLANK_EN
    logic w_lead;
`endif

    always_comb begin
        w_capture = {bus.display5, bus.display4, bus.display3,
                     bus.display2, bus.display1, bus.display0};
`ifdef LEADING_ZERO_BLANK_EN
        // Walk down from the most significant digit while it shows "0";
        // digit 0 is excluded so a value of zero still displays.
        w_lead = 1'b1;
        for (int i = 5; i >= 1; i--) begin
            if (w_lead && (w_capture[i] == 8'b1100_0000)) begin
                w_capture[i] = c_seg_off;
            end else begin
                w_lead = 1'b0;
            end
        end
`endif
    end

    // ------------------------------------------------------------------
    // Next-state logic. en low wins over any phase end or wrap.
    // ------------------------------------------------------------------
    always_comb begin
        w_state      = r_state;
        w_idx        = r_idx;
        w_cnt        = r_cnt;
        w_load       = 1'b0;
        w_frame_done = 1'b0;

        if (!bus.en) begin
            w_state = S_IDLE;
            w_idx   = 3'd0;
            w_cnt   = '0;
        end else if (r_first || (r_state == S_IDLE)) begin
            // Start of a frame from reset or parked: fresh snapshot, digit 0.
            w_load  = 1'b1;
            w_idx   = 3'd0;
            w_cnt   = '0;
            w_state = c_skip_blank ? S_ON : S_BLANK;
        end else begin
            case (r_state)
                S_BLANK: begin
                    if (r_cnt == c_blank_last) begin
                        w_state = S_ON;
                        w_cnt   = '0;
                    end else begin
                        w_cnt = r_cnt + cnt_t'(1);
                    end
                end
                S_ON: begin
                    if (r_cnt == c_dwell_last) begin
                        w_cnt   = '0;
                        w_state = c_skip_blank ? S_ON : S_BLANK;
                        if (r_idx == c_last_idx) begin
                            w_idx        = 3'd0;
                            w_frame_done = 1'b1;
                            w_load       = 1'b1;
                        end else begin
                            w_idx = r_idx + 3'd1;
                        end
                    end else begin
                        w_cnt = r_cnt + cnt_t'(1);
                    end
                end
                default: begin
                    w_state = S_IDLE;
                    w_idx   = 3'd0;
                    w_cnt   = '0;
                end
            endcase
        end
    end

    // Outputs are derived from the next state so that seg and an always
    // refer to the same digit in the same cycle.
    always_comb begin
        w_snap = w_load ? w_capture : r_snap;
        w_seg  = c_seg_off;
        w_an   = c_an_off;
        if (w_state == S_ON) begin
            w_seg        = w_snap[w_idx];
            w_an[w_idx]  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_BLANK;
            r_idx        <= 3'd0;
            r_cnt        <= '0;
            r_first      <= 1'b1;
            r_snap       <= {6{c_seg_off}};
            r_seg        <= c_seg_off;
            r_an         <= c_an_off;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_idx        <= w_idx;
            r_cnt        <= w_cnt;
            r_first      <= 1'b0;
            r_snap       <= w_snap;
            r_seg        <= w_seg;
            r_an         <= w_an;
            r_frame_done <= w_frame_done;
        end
    end

    assign bus.seg        = r_seg;
    assign bus.an         = r_an;
    assign bus.frame_done = r_frame_done;

endmodule
`default_nettype wire
